exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle control FSM for the 20-bit-instruction datapath: latches each instruction, sequences fetch, decode, execute and writeback, and drives the PC hold, the register-file write enable/address, and a start/done handshake to a multi-cycle ALU. Sits between `pc_instruction` (it drives `hold`), `decoder`/ALU and `data_memory` (it drives `writeBack`). A watchdog and illegal-opcode detection stop the core in a defined state.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles allowed for `alu_done`; range 1–255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `instruction` in 20: current word from `pc_instruction`; [19:16] opcode, [15:8] destination/select1, [7:0] select2.
- `alu_done` in 1: multi-cycle ALU result valid; sampled only in WAIT.
- `step` in 1: single-step advance pulse; used only with `SEQ_STEP_EN`.
- `pc_hold` out 1: 0 for exactly one cycle per retired instruction; the PC advances on that edge.
- `reg_we` out 1: one-cycle register write strobe.
- `reg_waddr` out 8: latched instruction[15:8].
- `alu_op` out 3: latched opcode[2:0].
- `alu_start` out 1: one-cycle pulse launching a multi-cycle op.
- `busy` out 1: high in every state except FETCH and HALT.
- `halted` out 1: high in HALT.
- `err_illegal` out 1: sticky; an illegal opcode was decoded.
- `err_timeout` out 1: sticky; the watchdog expired.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, WAIT=3, WB=4, HALT=5.

## Operation
- Reset value of every output: `pc_hold`=1, `reg_we`=0, `alu_start`=0, `busy`=0, `halted`=0, both error flags 0, `reg_waddr`=0, `alu_op`=0, `state`=FETCH. Internal IR and watchdog counter also clear to 0.
- FETCH: `instruction` latched into IR at the end of the cycle, then go to DECODE.
- DECODE, opcode classes:
  - 0x0 NOP: `pc_hold`=0 this cycle, then FETCH.
  - 0x1–0x7 single-cycle ALU op: go to EXEC.
  - 0x8–0xB multi-cycle op: go to EXEC.
  - 0xC–0xE illegal: set `err_illegal`; otherwise handled as NOP.
  - 0xF HALT: go to HALT with no writeback and no PC advance.
- EXEC:
  - Single-cycle op: go to WB.
  - Multi-cycle op: `alu_start`=1 this cycle, clear the watchdog, go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - `alu_done`=1 goes to WB.
  - Watchdog reaching `TIMEOUT` with `alu_done` still low: set `err_timeout`, go to HALT, no write.
  - `alu_done` high in the same cycle the count reaches `TIMEOUT`: done wins.
- WB: `reg_we`=1 and `pc_hold`=0 for this one cycle, then FETCH.
- HALT: absorbing state. `pc_hold`=1, `reg_we`=0, `halted`=1. Only `reset` leaves it.
- `alu_done` outside WAIT is ignored. A spurious done never writes.
- Watchdog is 8 bits and saturates. It never wraps.

## Timing
- NOP or illegal: 2 cycles per instruction (FETCH, DECODE).
- Single-cycle op: 4 cycles (FETCH, DECODE, EXEC, WB).
- Multi-cycle op: 4 + N cycles, where N is the number of WAIT cycles up to and including the one where `alu_done` is sampled high. Minimum N=1.
- `reg_waddr` and `alu_op` are stable from the cycle after FETCH until the next FETCH ends.
- `reset` assertion in any state forces all outputs to reset values immediately. An in-flight write is dropped (`reg_we` goes low asynchronously).
- After `reset` deasserts, the first FETCH starts on the next rising edge.

## Configuration
- `SEQ_STEP_EN` defined: FETCH stays in FETCH until `step`=1 is sampled, then latches IR and proceeds. Exactly one instruction executes per `step` pulse. A `step` held high runs freely.
- `SEQ_STEP_EN` undefined: `step` is ignored and FETCH always lasts one cycle.

## Test plan
- Reset, then opcode 0x3, dest 0x02 -> `reg_we`=1 with `reg_waddr`=0x02 on cycle 4; `pc_hold` low only on that cycle; next FETCH on cycle 5.
- Opcode 0x9, `alu_done` raised 3 cycles after `alu_start` -> exactly one `alu_start` pulse in EXEC, WB on cycle 7, one write.
- Opcode 0x8 with `alu_done` never asserted, `TIMEOUT`=15 -> `err_timeout`=1 after 15 WAIT cycles, `halted`=1, no `reg_we`; `reset` low clears everything.
- Opcode 0xD followed by 0x0 -> `err_illegal` set and stays set; each instruction takes 2 cycles; no writes.
- Opcode 0xF -> HALT from cycle 3; `pc_hold` stays 1 over 20 cycles while `alu_done` and `step` toggle.
- `reset` pulsed low during WB -> `reg_we` drops immediately; `state`=FETCH; error flags cleared.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Signal bundle between exec_sequencer and the surrounding datapath.
// master: the sequencer side; slave: the datapath/environment side.
interface exec_sequencer_if;
  logic [19:0] instruction;
  logic        alu_done;
  logic        step;
  logic        pc_hold;
  logic        reg_we;
  logic [7:0]  reg_waddr;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        busy;
  logic        halted;
  logic        err_illegal;
  logic        err_timeout;
  logic [2:0]  state;

  modport master (
    input  instruction, alu_done, step,
    output pc_hold, reg_we, reg_waddr, alu_op, alu_start, busy, halted,
           err_illegal, err_timeout, state
  );

  modport slave (
    output instruction, alu_done, step,
    input  pc_hold, reg_we, reg_waddr, alu_op, alu_start, busy, halted,
           err_illegal, err_timeout, state
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/wait/writeback with ALU watchdog and HALT.
// Optional single-step FETCH gating is enabled by defining SEQ_STEP_EN.
module exec_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  exec_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWait   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [19:0] ir_q, ir_d;
  logic [7:0]  wd_q, wd_d;
  logic        err_ill_q, err_ill_d;
  logic        err_to_q, err_to_d;
  logic        pc_hold, reg_we, alu_start;
  logic        fetch_go;

  logic [3:0] opcode;
  logic       is_nop, is_multi, is_illegal, is_halt;
  logic [7:0] wd_inc;

  assign opcode     = ir_q[19:16];
  assign is_nop     = (opcode == 4'h0);
  assign is_multi   = (opcode[3:2] == 2'b10);
  assign is_illegal = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
  assign is_halt    = (opcode == 4'hF);
  // Saturating increment so the watchdog can never wrap back under TIMEOUT.
  assign wd_inc     = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

`ifdef SEQ_STEP_EN
  assign fetch_go = bus.step;
`else
  assign fetch_go = 1'b1;
  logic unused_step;
  assign unused_step = bus.step;
`endif

  logic unused_ir;
  assign unused_ir = ^ir_q[7:0];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wd_d      = wd_q;
    err_ill_d = err_ill_q;
    err_to_d  = err_to_q;
    pc_hold   = 1'b1;
    reg_we    = 1'b0;
    alu_start = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (fetch_go) begin
          ir_d    = bus.instruction;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_nop || is_illegal) begin
          pc_hold = 1'b0;
          if (is_illegal) err_ill_d = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_multi) begin
          alu_start = 1'b1;
          wd_d      = 8'd0;
          state_d   = StWait;
        end else begin
          state_d = StWb;
        end
      end
      StWait: begin
        wd_d = wd_inc;
        // A done sampled in the expiring cycle still retires the instruction.
        if (bus.alu_done) begin
          state_d = StWb;
        end else if (wd_inc >= TimeoutCnt) begin
          err_to_d = 1'b1;
          state_d  = StHalt;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_hold = 1'b0;
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      wd_q      <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wd_q      <= wd_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

  // Outputs decode from the registered state, so reset drops them asynchronously.
  assign bus.pc_hold     = pc_hold;
  assign bus.reg_we      = reg_we;
  assign bus.alu_start   = alu_start;
  assign bus.reg_waddr   = ir_q[15:8];
  assign bus.alu_op      = ir_q[18:16];
  assign bus.busy        = (state_q != StFetch) && (state_q != StHalt);
  assign bus.halted      = (state_q == StHalt);
  assign bus.err_illegal = err_ill_q;
  assign bus.err_timeout = err_to_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (default TIMEOUT=15, step disabled).
module tb_exec_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  exec_sequencer_if bus();

  exec_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    reset           = 1'b0;
    bus.instruction = 20'h0;
    bus.alu_done    = 1'b0;
    bus.step        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk1("rst pc_hold", bus.pc_hold, 1'b1);
    chk1("rst reg_we", bus.reg_we, 1'b0);
    chk1("rst alu_start", bus.alu_start, 1'b0);
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst halted", bus.halted, 1'b0);
    chk1("rst err_illegal", bus.err_illegal, 1'b0);
    chk1("rst err_timeout", bus.err_timeout, 1'b0);
    chk8("rst reg_waddr", bus.reg_waddr, 8'h00);
    chk8("rst alu_op", 8'(bus.alu_op), 8'h00);
    chk8("rst state", 8'(bus.state), 8'd0);

    // Single-cycle op 0x3, dest 0x02
    bus.instruction = 20'h3_02_55;
    reset = 1'b1;
    chk8("op3 c1 state", 8'(bus.state), 8'd0);
    tick();
    chk8("op3 c2 state", 8'(bus.state), 8'd1);
    chk8("op3 c2 waddr", bus.reg_waddr, 8'h02);
    chk8("op3 c2 alu_op", 8'(bus.alu_op), 8'h3);
    chk1("op3 c2 pc_hold", bus.pc_hold, 1'b1);
    chk1("op3 c2 busy", bus.busy, 1'b1);
    bus.instruction = 20'h0_00_00;
    tick();
    chk8("op3 c3 state", 8'(bus.state), 8'd2);
    chk1("op3 c3 alu_start", bus.alu_start, 1'b0);
    chk1("op3 c3 pc_hold", bus.pc_hold, 1'b1);
    tick();
    chk8("op3 c4 state", 8'(bus.state), 8'd4);
    chk1("op3 c4 reg_we", bus.reg_we, 1'b1);
    chk1("op3 c4 pc_hold", bus.pc_hold, 1'b0);
    chk8("op3 c4 waddr", bus.reg_waddr, 8'h02);
    tick();
    chk8("op3 c5 state", 8'(bus.state), 8'd0);
    chk1("op3 c5 reg_we", bus.reg_we, 1'b0);
    chk1("op3 c5 pc_hold", bus.pc_hold, 1'b1);

    // NOP takes two cycles, advances PC in DECODE
    tick();
    chk8("nop decode state", 8'(bus.state), 8'd1);
    chk1("nop pc_hold", bus.pc_hold, 1'b0);
    chk1("nop reg_we", bus.reg_we, 1'b0);
    bus.instruction = 20'h9_07_00;
    tick();
    chk8("nop next fetch", 8'(bus.state), 8'd0);

    // Multi-cycle op 0x9, done 3 cycles after start
    tick();
    chk8("op9 c2 alu_op", 8'(bus.alu_op), 8'h1);
    chk8("op9 c2 waddr", bus.reg_waddr, 8'h07);
    tick();
    chk8("op9 c3 state", 8'(bus.state), 8'd2);
    chk1("op9 c3 alu_start", bus.alu_start, 1'b1);
    tick();
    chk8("op9 c4 state", 8'(bus.state), 8'd3);
    chk1("op9 c4 alu_start", bus.alu_start, 1'b0);
    tick();
    chk1("op9 c5 reg_we", bus.reg_we, 1'b0);
    tick();
    chk8("op9 c6 state", 8'(bus.state), 8'd3);
    bus.alu_done = 1'b1;
    tick();
    chk8("op9 c7 state", 8'(bus.state), 8'd4);
    chk1("op9 c7 reg_we", bus.reg_we, 1'b1);
    chk8("op9 c7 waddr", bus.reg_waddr, 8'h07);
    bus.alu_done    = 1'b0;
    bus.instruction = 20'h8_05_00;
    tick();
    chk1("op9 c8 reg_we", bus.reg_we, 1'b0);

    // Op 0x8 with done never asserted: watchdog expires after 15 WAIT cycles
    tick();
    tick();
    chk1("op8 exec alu_start", bus.alu_start, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk8($sformatf("op8 wait%0d state", i), 8'(bus.state), 8'd3);
      chk1($sformatf("op8 wait%0d reg_we", i), bus.reg_we, 1'b0);
    end
    tick();
    chk8("op8 halt state", 8'(bus.state), 8'd5);
    chk1("op8 halted", bus.halted, 1'b1);
    chk1("op8 err_timeout", bus.err_timeout, 1'b1);
    chk1("op8 reg_we", bus.reg_we, 1'b0);
    chk1("op8 pc_hold", bus.pc_hold, 1'b1);
    chk1("op8 busy", bus.busy, 1'b0);
    reset = 1'b0;
    #1;
    chk1("op8 rst err_timeout", bus.err_timeout, 1'b0);
    chk1("op8 rst halted", bus.halted, 1'b0);
    chk8("op8 rst state", 8'(bus.state), 8'd0);

    // Op 0xA with done in the 15th WAIT cycle: done wins over timeout
    bus.instruction = 20'hA_33_00;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    repeat (15) tick();
    chk8("opA wait15 state", 8'(bus.state), 8'd3);
    bus.alu_done = 1'b1;
    tick();
    chk8("opA wb state", 8'(bus.state), 8'd4);
    chk1("opA wb reg_we", bus.reg_we, 1'b1);
    chk8("opA wb waddr", bus.reg_waddr, 8'h33);
    chk1("opA err_timeout", bus.err_timeout, 1'b0);
    bus.alu_done    = 1'b0;
    bus.instruction = 20'hD_44_00;
    tick();

    // Illegal 0xD then NOP
    tick();
    chk8("opD decode state", 8'(bus.state), 8'd1);
    chk1("opD pc_hold", bus.pc_hold, 1'b0);
    chk1("opD reg_we", bus.reg_we, 1'b0);
    bus.instruction = 20'h0_00_00;
    tick();
    chk8("opD next fetch", 8'(bus.state), 8'd0);
    chk1("opD err_illegal", bus.err_illegal, 1'b1);
    tick();
    chk1("nop2 pc_hold", bus.pc_hold, 1'b0);
    chk1("nop2 err_illegal", bus.err_illegal, 1'b1);
    bus.instruction = 20'h1_0A_00;
    tick();
    chk1("nop2 fetch err_illegal", bus.err_illegal, 1'b1);

    // Reset pulsed during WB drops the write at once
    tick();
    tick();
    chk1("op1 exec alu_start", bus.alu_start, 1'b0);
    tick();
    chk1("op1 wb reg_we", bus.reg_we, 1'b1);
    chk8("op1 wb waddr", bus.reg_waddr, 8'h0A);
    #2;
    reset = 1'b0;
    #1;
    chk1("wbrst reg_we", bus.reg_we, 1'b0);
    chk8("wbrst state", 8'(bus.state), 8'd0);
    chk1("wbrst err_illegal", bus.err_illegal, 1'b0);
    chk1("wbrst pc_hold", bus.pc_hold, 1'b1);
    chk8("wbrst waddr", bus.reg_waddr, 8'h00);

    // HALT 0xF is absorbing
    bus.instruction = 20'hF_00_00;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk8("opF c2 state", 8'(bus.state), 8'd1);
    chk1("opF c2 pc_hold", bus.pc_hold, 1'b1);
    tick();
    chk8("opF c3 state", 8'(bus.state), 8'd5);
    chk1("opF c3 halted", bus.halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.alu_done = 1'(i & 1);
      bus.step     = 1'(~i & 1);
      tick();
      chk1($sformatf("halt%0d pc_hold", i), bus.pc_hold, 1'b1);
      chk8($sformatf("halt%0d state", i), 8'(bus.state), 8'd5);
      chk1($sformatf("halt%0d reg_we", i), bus.reg_we, 1'b0);
    end
    chk1("halt err_timeout", bus.err_timeout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
